branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 132 +++++++++++++
 tb/tb_branch_resolve.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolve: evaluates the branch condition from comparator flags; optional counters under BRANCH_RESOLVE_STATS_EN.
// Latency: 1 cycle from accept to resolved/taken/redirect; flush_o lasts FLUSH_DEPTH cycles after a taken branch.
// Backpressure: ready_o is low for the whole flush, and the source must hold its operation until it is accepted.
module branch_resolve #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  funct3_i,
  input  logic        equal_i,
  input  logic        alarger_i,
  input  logic        blarger_i,
  input  logic        a_sign_i,
  input  logic        b_sign_i,
  input  logic [31:0] target_i,
  output logic        resolved_o,
  output logic        taken_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        illegal_o,
  output logic        flag_err_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [15:0] taken_cnt_o,
  output logic [15:0] nottaken_cnt_o
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  // The counter holds the flush cycles remaining after the current one.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_DEPTH - 1);

  logic [0:0]  state_q;
  logic [2:0]  cnt_q;
  logic [31:0] pc_q;
  logic        resolved_q, taken_q, redirect_q, illegal_q, flag_err_q;

  logic flags_ok, lt_s, legal, cond, taken_w, accept;

  always_comb begin
    flags_ok = 1'b0;
    case ({equal_i, alarger_i, blarger_i})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // On a sign mismatch, the negative operand is the smaller one.
  assign lt_s = (a_sign_i != b_sign_i) ? a_sign_i : blarger_i;

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (funct3_i)
      3'b000:  cond = equal_i;
      3'b001:  cond = ~equal_i;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = blarger_i;
      3'b111:  cond = ~blarger_i;
      default: legal = 1'b0;
    endcase
  end

  assign taken_w = legal & flags_ok & cond;
  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pc_q       <= 32'd0;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      resolved_q <= accept;
      taken_q    <= accept & taken_w;
      redirect_q <= accept & taken_w;
      illegal_q  <= accept & ~legal;
      flag_err_q <= accept & ~flags_ok;
      if (state_q == IDLE) begin
        if (accept && taken_w) begin
          state_q <= FLUSH;
          cnt_q   <= CNT_LOAD;
          pc_q    <= target_i;
        end
      end else if (cnt_q == 3'd0) begin
        state_q <= IDLE;
        pc_q    <= 32'd0;
      end else begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  assign resolved_o    = resolved_q;
  assign taken_o       = taken_q;
  assign redirect_o    = redirect_q;
  assign illegal_o     = illegal_q;
  assign flag_err_o    = flag_err_q;
  assign flush_o       = (state_q == FLUSH);
  assign redirect_pc_o = flush_o ? pc_q : 32'd0;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_q    <= 16'd0;
      nottaken_cnt_q <= 16'd0;
    end else if (accept) begin
      if (taken_w) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (nottaken_cnt_q != 16'hFFFF) nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt_o    = taken_cnt_q;
  assign nottaken_cnt_o = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: operands are real 32-bit values, flags derived from them.
module tb_branch_resolve;
  localparam int D = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o;
  logic [2:0]  funct3_i;
  logic        equal_i, alarger_i, blarger_i, a_sign_i, b_sign_i;
  logic [31:0] target_i, redirect_pc_o;
  logic        resolved_o, taken_o, redirect_o, flush_o, illegal_o, flag_err_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] taken_cnt_o, nottaken_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  branch_resolve #(.FLUSH_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .equal_i(equal_i), .alarger_i(alarger_i), .blarger_i(blarger_i),
    .a_sign_i(a_sign_i), .b_sign_i(b_sign_i), .target_i(target_i),
    .resolved_o(resolved_o), .taken_o(taken_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .illegal_o(illegal_o),
    .flag_err_o(flag_err_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .taken_cnt_o(taken_cnt_o), .nottaken_cnt_o(nottaken_cnt_o)
`endif
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic        ready, resolved, taken, redirect, flush, illegal, flag_err;
    logic [31:0] pc;
    logic [15:0] tc, nc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Reference state: flush cycles still owed, latched target, op counts.
  int          m_left = 0;
  logic [31:0] m_pc = 32'd0;
  int          m_tc = 0;
  int          m_nc = 0;

  always @(posedge clk_i) cyc = cyc + 1;

  task automatic step(input string tag, input logic rst, input logic v, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic use_ovr, input logic [2:0] ovr, input logic [31:0] tgt);
    exp_t e;
    logic [2:0] fl;
    logic legal, fok, c, tk;
    fl = use_ovr ? ovr : {a == b, a > b, a < b};
    rst_i = rst; valid_i = v; funct3_i = f3; target_i = tgt;
    equal_i = fl[2]; alarger_i = fl[1]; blarger_i = fl[0];
    a_sign_i = a[31]; b_sign_i = b[31];
    e = '{cyc: cyc + 1, tag: tag, ready: 1'b0, resolved: 1'b0, taken: 1'b0, redirect: 1'b0,
          flush: 1'b0, illegal: 1'b0, flag_err: 1'b0, pc: 32'd0, tc: 16'd0, nc: 16'd0};
    if (rst) begin
      m_left = 0; m_pc = 32'd0; m_tc = 0; m_nc = 0;
    end else if (m_left == 0 && v) begin
      legal = !(f3 inside {3'b010, 3'b011});
      fok   = ($countones(fl) == 1);
      case (f3)
        3'b000:  c = (a == b);
        3'b001:  c = (a != b);
        3'b100:  c = ($signed(a) < $signed(b));
        3'b101:  c = ($signed(a) >= $signed(b));
        3'b110:  c = (a < b);
        3'b111:  c = (a >= b);
        default: c = 1'b0;
      endcase
      tk = legal && fok && c;
      e.resolved = 1'b1; e.illegal = !legal; e.flag_err = !fok;
      e.taken = tk; e.redirect = tk;
      if (tk) begin
        m_left = D; m_pc = tgt;
        if (m_tc < 65535) m_tc++;
      end else if (m_nc < 65535) m_nc++;
    end else if (m_left > 0) begin
      m_left--;
    end
    e.flush = (m_left > 0);
    e.ready = (m_left == 0);
    e.pc    = e.flush ? m_pc : 32'd0;
    e.tc    = 16'(m_tc);
    e.nc    = 16'(m_nc);
    q.push_back(e);
  endtask

  task automatic tick(input string tag, input logic rst, input logic v, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic use_ovr, input logic [2:0] ovr, input logic [31:0] tgt);
    @(posedge clk_i);
    #1;
    step(tag, rst, v, f3, a, b, use_ovr, ovr, tgt);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    logic [15:0] atc, anc;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      atc = e.tc; anc = e.nc;
`ifdef BRANCH_RESOLVE_STATS_EN
      atc = taken_cnt_o; anc = nottaken_cnt_o;
`endif
      checks++;
      if (e.cyc != cyc ||
          {ready_o, resolved_o, taken_o, redirect_o, flush_o, illegal_o, flag_err_o} !==
          {e.ready, e.resolved, e.taken, e.redirect, e.flush, e.illegal, e.flag_err} ||
          redirect_pc_o !== e.pc || atc !== e.tc || anc !== e.nc) begin
        failures++;
        $display("FAIL %s cyc=%0d got rdy/res/tk/rd/fl/ill/ferr=%b%b%b%b%b%b%b pc=%h cnt=%0d/%0d exp %b%b%b%b%b%b%b pc=%h cnt=%0d/%0d",
                 e.tag, cyc, ready_o, resolved_o, taken_o, redirect_o, flush_o, illegal_o, flag_err_o,
                 redirect_pc_o, atc, anc, e.ready, e.resolved, e.taken, e.redirect, e.flush,
                 e.illegal, e.flag_err, e.pc, e.tc, e.nc);
      end
    end
  end

  initial begin
    logic [2:0]  f3, ovr;
    logic [31:0] a, b, tgt;
    logic        v, use_ovr, rst;
    step("reset", 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    tick("reset", 1'b1, 1'b1, 3'b000, 32'd3, 32'd3, 1'b0, 3'b000, 32'h44);
    tick("reset", 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    // Taken BEQ, then held op during flush
    tick("beq_taken", 1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 1'b0, 3'b000, 32'h100);
    tick("beq_flush1", 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 1'b0, 3'b000, 32'h200);
    tick("beq_flush2", 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 1'b0, 3'b000, 32'h200);
    tick("held_bne", 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 1'b0, 3'b000, 32'h200);
    tick("held_flush", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    tick("held_flush", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    tick("idle", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    // Signed vs unsigned with a negative, b positive
    tick("blt_taken", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'd1, 1'b0, 3'b000, 32'h300);
    tick("blt_flush", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    tick("blt_flush", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    tick("bltu_nt", 1'b0, 1'b1, 3'b110, 32'h8000_0000, 32'd1, 1'b0, 3'b000, 32'h400);
    // Back-to-back not-taken BNE
    for (int i = 0; i < 3; i++)
      tick("bne_b2b", 1'b0, 1'b1, 3'b001, 32'd7, 32'd7, 1'b0, 3'b000, 32'h500);
    tick("illegal_f3", 1'b0, 1'b1, 3'b011, 32'd7, 32'd7, 1'b0, 3'b000, 32'h600);
    tick("flag_err", 1'b0, 1'b1, 3'b000, 32'd7, 32'd7, 1'b1, 3'b000, 32'h700);
    tick("both_err", 1'b0, 1'b1, 3'b010, 32'd7, 32'd7, 1'b1, 3'b111, 32'h700);
    // Reset in first flush cycle with valid held
    tick("rst_flush", 1'b0, 1'b1, 3'b000, 32'd9, 32'd9, 1'b0, 3'b000, 32'h800);
    tick("rst_flush", 1'b1, 1'b1, 3'b000, 32'd9, 32'd9, 1'b0, 3'b000, 32'h800);
    tick("post_rst", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    // Randomized traffic; the op is held while the reference model says the block is busy
    v = 1'b0; f3 = 3'b000; a = 32'd0; b = 32'd0; use_ovr = 1'b0; ovr = 3'b000; tgt = 32'd0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (m_left == 0 || rst) begin
        v   = ($urandom_range(0, 3) != 0);
        f3  = 3'($urandom_range(0, 7));
        a   = $urandom;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ 32'h8000_0000;
          2:       b = a + 32'($urandom_range(0, 3)) - 32'd1;
          default: b = $urandom;
        endcase
        use_ovr = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 4))
          0:       ovr = 3'b000;
          1:       ovr = 3'b011;
          2:       ovr = 3'b101;
          3:       ovr = 3'b110;
          default: ovr = 3'b111;
        endcase
        tgt = $urandom & 32'hFFFF_FFFC;
      end
      tick("random", rst, v, f3, a, b, use_ovr, ovr, tgt);
    end
    tick("drain", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
